// File: rtl/multicycle_control_fsm_if.sv
// Handshake and control bundle between the multicycle control unit and the datapath/memory side.
// master is the control unit's view; slave is the datapath/memory view.
interface multicycle_control_fsm_if;
  logic [31:0] instr;
  logic        ihit;
  logic        dhit;
  logic        zero;
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic        regWEN;
  logic        pcWEN;
  logic [1:0]  jsel;
  logic [1:0]  wsel;
  logic [1:0]  extsel;
  logic [1:0]  rdsel;
  logic        branch_taken;
  logic        halt;

  modport master (
    input  instr, ihit, dhit, zero,
    output iREN, dREN, dWEN, regWEN, pcWEN, jsel, wsel, extsel, rdsel, branch_taken, halt
  );

  modport slave (
    output instr, ihit, dhit, zero,
    input  iREN, dREN, dWEN, regWEN, pcWEN, jsel, wsel, extsel, rdsel, branch_taken, halt
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with
// decoded mux selects registered alongside the instruction register.
module multicycle_control_fsm (
  input logic                         CLK,
  input logic                         nRST,
  multicycle_control_fsm_if.master    cu
);

  localparam logic [5:0] OpR     = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0a;
  localparam logic [5:0] OpSltiu = 6'h0b;
  localparam logic [5:0] OpAndi  = 6'h0c;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpXori  = 6'h0e;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;
  localparam logic [5:0] OpHalt  = 6'h3f;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [1:0] JselDefault = 2'b00;
  localparam logic [1:0] JselJ       = 2'b01;
  localparam logic [1:0] JselJr      = 2'b10;
  localparam logic [1:0] WselAlu     = 2'b00;
  localparam logic [1:0] WselMem     = 2'b01;
  localparam logic [1:0] WselNpc     = 2'b10;
  localparam logic [1:0] WselImm     = 2'b11;
  localparam logic [1:0] ExtLsb      = 2'b00;
  localparam logic [1:0] ExtMsb      = 2'b01;
  localparam logic [1:0] ExtSign     = 2'b10;
  localparam logic [1:0] RdRd        = 2'b00;
  localparam logic [1:0] RdRt        = 2'b01;
  localparam logic [1:0] RdR31       = 2'b10;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExecute, StMemory, StWriteback, StHalt
  } state_e;

  state_e      state_q;
  logic [31:0] ir_q;
  logic [1:0]  jsel_q, wsel_q, extsel_q, rdsel_q;

  function automatic logic [1:0] dec_extsel(input logic [5:0] op);
    case (op)
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpLw, OpSw, OpBeq, OpBne: dec_extsel = ExtSign;
      OpLui:                                                      dec_extsel = ExtMsb;
      default:                                                    dec_extsel = ExtLsb;
    endcase
  endfunction

  function automatic logic [1:0] dec_wsel(input logic [5:0] op);
    case (op)
      OpLui:   dec_wsel = WselImm;
      OpJal:   dec_wsel = WselNpc;
      OpLw:    dec_wsel = WselMem;
      default: dec_wsel = WselAlu;
    endcase
  endfunction

  function automatic logic [1:0] dec_jsel(input logic [5:0] op, input logic [5:0] fn);
    if (op == OpJ || op == OpJal)     dec_jsel = JselJ;
    else if (op == OpR && fn == FnJr) dec_jsel = JselJr;
    else                              dec_jsel = JselDefault;
  endfunction

  function automatic logic [1:0] dec_rdsel(input logic [5:0] op);
    if (op == OpR)        dec_rdsel = RdRd;
    else if (op == OpJal) dec_rdsel = RdR31;
    else                  dec_rdsel = RdRt;
  endfunction

  logic [5:0] op, fn;
  logic       is_lw, is_sw, mem_op, wb_op;
  logic       unused_ir;

  assign op        = ir_q[31:26];
  assign fn        = ir_q[5:0];
  assign unused_ir = ^ir_q[25:6];
  assign is_lw     = (op == OpLw);
  assign is_sw     = (op == OpSw);
  assign mem_op    = is_lw || is_sw;
  // Instructions that end with a register write (JR is R-type but writes nothing).
  assign wb_op     = (op == OpR && fn != FnJr) || (op inside {[OpAddi:OpLui]}) || (op == OpJal);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StFetch;
      ir_q     <= '0;
      jsel_q   <= JselDefault;
      wsel_q   <= WselAlu;
      extsel_q <= ExtLsb;
      rdsel_q  <= RdRd;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (cu.ihit) begin
            ir_q     <= cu.instr;
            jsel_q   <= dec_jsel(cu.instr[31:26], cu.instr[5:0]);
            wsel_q   <= dec_wsel(cu.instr[31:26]);
            extsel_q <= dec_extsel(cu.instr[31:26]);
            rdsel_q  <= dec_rdsel(cu.instr[31:26]);
            state_q  <= StDecode;
          end
        end
        StDecode: state_q <= (op == OpHalt) ? StHalt : StExecute;
        StExecute: begin
          if (mem_op)     state_q <= StMemory;
          else if (wb_op) state_q <= StWriteback;
          else            state_q <= StFetch;
        end
        StMemory: begin
          if (cu.dhit) state_q <= is_lw ? StWriteback : StFetch;
        end
        StWriteback: state_q <= StFetch;
        StHalt:      state_q <= StHalt;
        default:     state_q <= StFetch;
      endcase
    end
  end

  assign cu.iREN         = (state_q == StFetch);
  assign cu.dREN         = (state_q == StMemory) && is_lw;
  assign cu.dWEN         = (state_q == StMemory) && is_sw;
  assign cu.regWEN       = (state_q == StWriteback);
  assign cu.pcWEN        = ((state_q == StExecute) && !mem_op && !wb_op)
                        || ((state_q == StMemory) && is_sw && cu.dhit)
                        || (state_q == StWriteback);
  assign cu.branch_taken = (state_q == StExecute)
                        && (((op == OpBeq) && cu.zero) || ((op == OpBne) && !cu.zero));
  assign cu.halt         = (state_q == StHalt);
  assign cu.jsel         = jsel_q;
  assign cu.wsel         = wsel_q;
  assign cu.extsel       = extsel_q;
  assign cu.rdsel        = rdsel_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for the multicycle control FSM.
module tb_multicycle_control_fsm;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  multicycle_control_fsm_if cu ();

  multicycle_control_fsm dut (
    .CLK  (CLK),
    .nRST (nRST),
    .cu   (cu)
  );

  typedef struct {
    logic       is_halt;
    int         lat;
    int         regw;
    int         iren;
    int         dren;
    int         dwen;
    int         bt;
    logic [1:0] jsel;
    logic [1:0] wsel;
    logic [1:0] extsel;
    logic [1:0] rdsel;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected behaviour per instruction, from opcode class and the handshake wait counts.
  function automatic exp_t model(input logic [31:0] ins, input int wi, input int wd,
                                 input logic z);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    e.is_halt = 1'b0; e.lat = wi + 3; e.regw = 0; e.iren = wi + 1; e.dren = 0; e.dwen = 0;
    e.bt = 0; e.jsel = 2'b00; e.wsel = 2'b00; e.extsel = 2'b00; e.rdsel = 2'b01;
    case (op)
      6'h00: begin
        e.rdsel = 2'b00;
        if (fn == 6'h08) e.jsel = 2'b10;
        else begin e.regw = 1; e.lat = wi + 4; end
      end
      6'h02: e.jsel = 2'b01;
      6'h03: begin e.jsel = 2'b01; e.wsel = 2'b10; e.rdsel = 2'b10; e.regw = 1; e.lat = wi + 4; end
      6'h04: begin e.extsel = 2'b10; e.bt = z ? 1 : 0; end
      6'h05: begin e.extsel = 2'b10; e.bt = z ? 0 : 1; end
      6'h08, 6'h09, 6'h0a, 6'h0b: begin e.extsel = 2'b10; e.regw = 1; e.lat = wi + 4; end
      6'h0c, 6'h0d, 6'h0e: begin e.regw = 1; e.lat = wi + 4; end
      6'h0f: begin e.extsel = 2'b01; e.wsel = 2'b11; e.regw = 1; e.lat = wi + 4; end
      6'h23: begin
        e.extsel = 2'b10; e.wsel = 2'b01; e.regw = 1; e.dren = wd + 1; e.lat = wi + wd + 5;
      end
      6'h2b: begin e.extsel = 2'b10; e.dwen = wd + 1; e.lat = wi + wd + 4; end
      6'h3f: e.is_halt = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int wi, input int wd, input logic z);
    int  mcnt;
    logic done;
    exp_q.push_back(model(ins, wi, wd, z));
    cu.instr = ins;
    cu.zero  = z;
    chk("fetch_ready", int'(cu.iREN), 1);
    for (int k = 0; k < wi; k++) begin
      cu.ihit = 1'b0;
      cu.dhit = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    cu.ihit = 1'b1;
    cu.dhit = 1'($urandom_range(0, 1));
    @(negedge CLK);
    cu.instr = $urandom;  // IR must hold the fetched word
    if (ins[31:26] == 6'h3f) return;
    mcnt = 0;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      cu.ihit = 1'($urandom_range(0, 1));
      if (cu.dREN || cu.dWEN) begin
        cu.dhit = (mcnt == wd);
        mcnt++;
      end else begin
        cu.dhit = 1'($urandom_range(0, 1));
      end
      #1 done = cu.pcWEN;
      @(negedge CLK);
    end
    chk("instr_done", int'(done), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_iREN"}, int'(cu.iREN), 1);
    chk({tag, "_enables"}, int'({cu.dREN, cu.dWEN, cu.regWEN, cu.pcWEN, cu.branch_taken}), 0);
    chk({tag, "_selects"}, int'({cu.jsel, cu.wsel, cu.extsel, cu.rdsel}), 0);
    chk({tag, "_halt"}, int'(cu.halt), 0);
  endtask

  // Monitor: accumulates per-instruction activity and scores it at the pcWEN cycle.
  initial begin : monitor
    int   cyc, regw, iren, dren, dwen, bt;
    logic halt_seen;
    exp_t e;
    cyc = 0; regw = 0; iren = 0; dren = 0; dwen = 0; bt = 0; halt_seen = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (!nRST) begin
        cyc = 0; regw = 0; iren = 0; dren = 0; dwen = 0; bt = 0; halt_seen = 1'b0;
      end else if (cu.halt) begin
        if (!halt_seen) begin
          halt_seen = 1'b1;
          cyc++;
          if (exp_q.size() == 0) chk("halt_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("halt_is_halt", int'(e.is_halt), 1);
            chk("halt_latency", cyc, e.lat);
          end
        end
        chk("halt_enables", int'({cu.iREN, cu.dREN, cu.dWEN, cu.regWEN, cu.pcWEN,
                                  cu.branch_taken}), 0);
      end else begin
        cyc++;
        regw += int'(cu.regWEN);
        iren += int'(cu.iREN);
        dren += int'(cu.dREN);
        dwen += int'(cu.dWEN);
        bt   += int'(cu.branch_taken);
        if (cu.pcWEN) begin
          if (exp_q.size() == 0) chk("pcwen_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("is_halt", int'(e.is_halt), 0);
            chk("latency", cyc, e.lat);
            chk("regWEN_count", regw, e.regw);
            chk("iREN_cycles", iren, e.iren);
            chk("dREN_cycles", dren, e.dren);
            chk("dWEN_cycles", dwen, e.dwen);
            chk("branch_taken", bt, e.bt);
            chk("jsel", int'(cu.jsel), int'(e.jsel));
            chk("wsel", int'(cu.wsel), int'(e.wsel));
            chk("extsel", int'(cu.extsel), int'(e.extsel));
            chk("rdsel", int'(cu.rdsel), int'(e.rdsel));
          end
          cyc = 0; regw = 0; iren = 0; dren = 0; dwen = 0; bt = 0;
        end
      end
    end
  end

  logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a,
                           6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b, 6'h10, 6'h31};

  initial begin : stimulus
    logic [31:0] ins;
    logic        seen;
    nRST     = 1'b0;
    cu.instr = '0;
    cu.ihit  = 1'b0;
    cu.dhit  = 1'b0;
    cu.zero  = 1'b0;
    #1;
    chk_reset_outputs("reset");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    run_instr(32'h20010005, 0, 0, 1'b0);  // ADDI
    run_instr(32'h8C220004, 0, 3, 1'b0);  // LW, dhit delayed
    run_instr(32'h10220003, 0, 0, 1'b1);  // BEQ taken
    run_instr(32'h10220003, 0, 0, 1'b0);  // BEQ not taken
    run_instr(32'h0C000010, 0, 0, 1'b0);  // JAL
    run_instr(32'h03E00008, 0, 0, 1'b0);  // JR
    run_instr(32'h3C01ABCD, 0, 0, 1'b0);  // LUI
    run_instr(32'h3421FFFF, 0, 0, 1'b0);  // ORI
    run_instr(32'hAC220008, 2, 1, 1'b1);  // SW with waits

    for (int i = 0; i < 80; i++) begin
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 17)];
      if (ins[31:26] == 6'h00 && $urandom_range(0, 2) == 0) ins[5:0] = 6'h08;
      run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    // Abort an LW mid-memory with an asynchronous reset.
    cu.instr = 32'h8C220004;
    cu.ihit  = 1'b1;
    cu.dhit  = 1'b0;
    @(negedge CLK);
    cu.ihit = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge CLK);
      seen = cu.dREN;
    end
    chk("lw_reached_memory", int'(seen), 1);
    #1 nRST = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(negedge CLK);
    nRST = 1'b1;

    run_instr(32'h20010005, 1, 0, 1'b0);
    run_instr(32'hAC220008, 0, 0, 1'b0);

    // HALT, then ihit/dhit toggling must not move the FSM.
    run_instr(32'hFFFFFFFF, 1, 0, 1'b0);
    for (int n = 0; n < 12; n++) begin
      cu.ihit = 1'($urandom_range(0, 1));
      cu.dhit = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    chk("halt_sticky", int'(cu.halt), 1);
    #1 nRST = 1'b0;
    #1;
    chk_reset_outputs("halt_reset");
    @(negedge CLK);
    nRST = 1'b1;
    run_instr(32'h20010005, 0, 0, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multicycle control state machine for the MIPS datapath. Latches each fetched instruction, sequences it through fetch/decode/execute/memory/writeback, and drives the datapath's select and enable signals. It produces the jump-select (`jctrl`), writeback-select (`wctrl`) and immediate-extend (`ectrl`) encodings defined in `cuif_types_pkg`, which the datapath muxes consume. Sits between the memory-request interface (ihit/dhit) and the datapath.

## Interface
- No parameters.
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction word from instruction memory; sampled only on FETCH & ihit.
- `ihit`  in  1  instruction memory done.
- `dhit`  in  1  data memory done.
- `zero`  in  1  ALU zero flag, valid in EXECUTE.
- `iREN`  out  1  instruction read request.
- `dREN` / `dWEN`  out  1 each  data read / write request.
- `regWEN`  out  1  register file write enable.
- `pcWEN`  out  1  PC update strobe.
- `jsel`  out  2  `jctrl`: ctrlDefault 00, ctrlJ 01, ctrlJR 10.
- `wsel`  out  2  `wctrl`: ALURESULT 00, MEMDATA 01, NPC 10, IMM 11.
- `extsel`  out  2  `ectrl`: LSB 00 (zero-ext), MSB 01 (imm<<16), SIGN 10.
- `rdsel`  out  2  write register: 00 rd, 01 rt, 10 r31.
- `branch_taken`  out  1  conditional branch resolved taken.
- `halt`  out  1  processor halted, sticky.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. Internal 32-bit IR.
- FETCH: iREN=1; on ihit latch `instr` into IR, go to DECODE; otherwise hold.
- DECODE: one cycle. If IR opcode is 6'b111111, go to HALT; else go to EXECUTE.
- EXECUTE: one cycle. LW/SW go to MEMORY. R-type (except JR), I-type ALU ops, LUI and JAL go to WRITEBACK. J, JR, BEQ, BNE and unknown opcodes go to FETCH with pcWEN=1.
- MEMORY: LW holds dREN=1 and SW holds dWEN=1 until dhit. On dhit, LW goes to WRITEBACK; SW goes to FETCH with pcWEN=1 in the dhit cycle.
- WRITEBACK: regWEN=1 and pcWEN=1 for one cycle, then FETCH.
- HALT: absorbing state; halt=1 and all enables 0 until nRST.
- Per instruction, pcWEN pulses exactly once, in its final cycle. regWEN pulses at most once.
- Decoded outputs come from IR and are held stable from DECODE to the end of the instruction.
  - extsel: SIGN for ADDI/ADDIU/SLTI/SLTIU/LW/SW/BEQ/BNE; LSB for ANDI/ORI/XORI; MSB for LUI; LSB otherwise.
  - wsel: IMM for LUI; NPC for JAL; MEMDATA for LW; ALURESULT otherwise.
  - jsel: ctrlJ for J/JAL; ctrlJR for R-type with funct 6'b001000; ctrlDefault otherwise.
  - rdsel: rd for R-type, r31 for JAL, rt otherwise.
  - branch_taken = EXECUTE & ((BEQ & zero) | (BNE & ~zero)); 0 in all other states.
- Opcodes: R 000000, J 000010, JAL 000011, BEQ 000100, BNE 000101, ADDI 001000, ADDIU 001001, SLTI 001010, SLTIU 001011, ANDI 001100, ORI 001101, XORI 001110, LUI 001111, LW 100011, SW 101011, HALT 111111.
- JR does not write a register. An unknown opcode is a NOP: no regWEN, no memory access.

## Timing
- Reset (nRST=0, asynchronous): state=FETCH, IR=0, halt=0.
  - While in reset: iREN=1; dREN, dWEN, regWEN, pcWEN and branch_taken are 0.
  - While in reset: jsel=00, wsel=00, extsel=00, rdsel=00.
- Enables and branch_taken are combinational from state (and zero); no extra latency.
- Latency with ihit/dhit on their first request cycle:
  - R/I/LUI/JAL: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - J/JR/BEQ/BNE/unknown: 3 cycles.
  - HALT: halt=1 from cycle 3.
- ihit outside FETCH and dhit outside MEMORY are ignored. With ihit and dhit both high in MEMORY, only dhit counts.
- Reset asserted mid-instruction aborts the instruction immediately; no pcWEN or regWEN occurs after the reset edge.
- Wait states: each cycle without ihit/dhit extends FETCH/MEMORY by one cycle; request outputs stay high throughout.

## Test plan
- ADDI r1,r0,5 (0x20010005), ihit immediate → iREN only in cycle 1; extsel=10, wsel=00, rdsel=01; regWEN and pcWEN both 1 only in cycle 4.
- LW (0x8C220004) with dhit delayed 3 cycles → dREN high 4 cycles; wsel=01; regWEN pulse in cycle 8; pcWEN exactly once.
- BEQ (0x10220003):
  - zero=1 → branch_taken=1 and pcWEN=1 in cycle 3, regWEN never asserted.
  - Repeat with zero=0 → branch_taken=0.
- JAL (0x0C000010) → jsel=01, wsel=10, rdsel=10, regWEN in cycle 4. JR (0x03E00008) → jsel=10, pcWEN in cycle 3, no regWEN.
- LUI (0x3C01ABCD) → extsel=01, wsel=11. ORI (0x3421FFFF) → extsel=00.
- HALT (0xFFFFFFFF) → halt=1 from cycle 3 and stays 1 with ihit toggling. nRST pulse mid-LW while dREN=1 → all outputs at reset values immediately, restart in FETCH.
